dac_sample_scheduler: RTL

// Sample-rate scheduler in front of delta_sigma_dac. Buffers 8-bit samples from an upstream

---
 rtl/dac_sample_scheduler_if.sv | 35 +++
 rtl/dac_sample_scheduler.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dac_sample_scheduler_if.sv
// +------------------------------------------------------------------------+
// | Module : dac_sample_scheduler_if                                       |
// | Brief  : Producer / control / DAC-side bundle of dac_sample_scheduler  |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

interface dac_sample_scheduler_if #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              enable;
   logic              mute;
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] dac_data;
   logic              sample_tick;
   logic              underrun;
   logic [LVL_W-1:0]  fifo_level;

   modport master (
      output enable, mute, s_data, s_valid,
      input  s_ready, dac_data, sample_tick, underrun, fifo_level
   );

   modport slave (
      input  enable, mute, s_data, s_valid,
      output s_ready, dac_data, sample_tick, underrun, fifo_level
   );
endinterface

`default_nettype wire

// File: rtl/dac_sample_scheduler.sv
// +------------------------------------------------------------------------+
// | Module : dac_sample_scheduler                                          |
// | Brief  : FIFO-buffered sample pacing with underrun flag and soft mute  |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module dac_sample_scheduler #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int SAMPLE_DIV = 256,
   parameter int MUTE_STEP  = 1
) (
   input  wire logic              clk,
   input  wire logic              rst,
   dac_sample_scheduler_if.slave  bus
);
   localparam int c_AW    = $clog2(FIFO_DEPTH);
   localparam int c_LVL_W = c_AW + 1;
   localparam int c_DIV_W = $clog2(SAMPLE_DIV);

   localparam logic [DATA_W-1:0]  c_MID      = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W:0]    c_STEP     = (DATA_W+1)'(MUTE_STEP);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SAMPLE_DIV - 1);
   localparam logic [c_LVL_W-1:0] c_FULL     = c_LVL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_MUTING = 2'd2,
      S_MUTED  = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [c_DIV_W-1:0]  r_div, w_div_nxt;
   logic [DATA_W-1:0]   r_dac, w_dac_nxt;
   logic                r_tick, w_tick_nxt;
   logic                r_under, w_under_nxt;
   logic                w_pop, w_flush, w_push, w_ready, w_empty, w_div_last;

   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [c_LVL_W-1:0]  r_level;

   logic                w_above;
   logic [DATA_W-1:0]   w_dist, w_step, w_ramp;

   assign w_empty    = (r_level == '0);
   assign w_ready    = (r_state != S_IDLE) && (r_level != c_FULL);
   assign w_push     = bus.s_valid & w_ready;
   assign w_div_last = (r_div == c_DIV_LAST);

   // One ramp step toward midscale, clamped so it lands exactly on MID.
   assign w_above = (r_dac > c_MID);
   assign w_dist  = w_above ? (r_dac - c_MID) : (c_MID - r_dac);
   assign w_step  = ({1'b0, w_dist} < c_STEP) ? w_dist : c_STEP[DATA_W-1:0];
   assign w_ramp  = w_above ? (r_dac - w_step) : (r_dac + w_step);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_dac   <= c_MID;
         r_tick  <= 1'b0;
         r_under <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_dac   <= w_dac_nxt;
         r_tick  <= w_tick_nxt;
         r_under <= w_under_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_dac_nxt   = r_dac;
      w_tick_nxt  = 1'b0;
      w_under_nxt = r_under;
      w_pop       = 1'b0;
      w_flush     = 1'b0;
      if (!bus.enable) begin
         w_state_nxt = S_IDLE;
         w_div_nxt   = '0;
         w_dac_nxt   = c_MID;
         w_flush     = 1'b1;
      end else if (r_state == S_IDLE) begin
         w_state_nxt = S_RUN;
         w_div_nxt   = '0;
         w_under_nxt = 1'b0;
         w_flush     = 1'b1;
      end else begin
         w_div_nxt  = w_div_last ? '0 : r_div + c_DIV_W'(1);
         w_tick_nxt = w_div_last;
         case (r_state)
            S_RUN: begin
               if (w_div_last) begin
                  if (w_empty) begin
                     w_under_nxt = 1'b1;
                  end else begin
                     w_pop     = 1'b1;
                     w_dac_nxt = r_mem[r_rd_ptr];
                  end
               end
               if (bus.mute) w_state_nxt = S_MUTING;
            end
            S_MUTING: begin
               // Popped entries are discarded so the stream stays time-aligned.
               if (w_div_last) begin
                  w_pop     = !w_empty;
                  w_dac_nxt = w_ramp;
                  if (w_ramp == c_MID) w_state_nxt = S_MUTED;
               end
               if (!bus.mute) w_state_nxt = S_RUN;
            end
            S_MUTED: begin
               if (w_div_last) begin
                  w_pop     = !w_empty;
                  w_dac_nxt = c_MID;
               end
               if (!bus.mute) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.s_data;
   end

   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_LVL_W'(1);
            2'b01:   r_level <= r_level - c_LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign bus.s_ready     = w_ready;
   assign bus.dac_data    = r_dac;
   assign bus.sample_tick = r_tick;
   assign bus.underrun    = r_under;
   assign bus.fifo_level  = r_level;
endmodule

`default_nettype wire
